// File: rtl/count_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : count_sequencer
// Brief    : Owns a WIDTH-bit count register and sequences it through a
//            multi-pass up/down run, reporting busy, wrap and done.
// Revision : 1.0 - initial release
// ============================================================================
module count_sequencer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic [1:0]       passes,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_dir;
    logic [WIDTH-1:0] r_limit;
    logic [1:0]       r_passes;
    logic [1:0]       r_pass_cnt;

    logic [WIDTH-1:0] w_end_val;
    logic [WIDTH-1:0] w_start_val;

    // The start value of a pass is the end value of the opposite direction.
    assign w_end_val   = r_dir ? '0 : r_limit;
    assign w_start_val = r_dir ? r_limit : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_dir      <= 1'b0;
            r_limit    <= '0;
            r_passes   <= 2'd0;
            r_pass_cnt <= 2'd0;
            Q          <= '0;
            busy       <= 1'b0;
            wrap       <= 1'b0;
            done       <= 1'b0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_dir      <= dir;
                        r_limit    <= limit;
                        r_passes   <= passes;
                        r_pass_cnt <= 2'd0;
                        Q          <= dir ? limit : '0;
                        busy       <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        Q       <= '0;
                        busy    <= 1'b0;
                    end else if (!hold) begin
                        if (Q != w_end_val) begin
                            Q <= r_dir ? (Q - c_one) : (Q + c_one);
                        end else if (r_pass_cnt != r_passes) begin
                            Q          <= w_start_val;
                            r_pass_cnt <= r_pass_cnt + 2'd1;
                            wrap       <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
